// File: rtl/morse_symbol_assembler.sv
// -----------------------------------------------------------------------------
// morse_symbol_assembler
//
// Collects the dot/dash/space stream from the button converter into a pattern
// register and, on each space, emits one character code for the display.
//
// Ports:
//   clk         in   1   system clock, rising edge
//   reset_n     in   1   asynchronous reset, active low
//   enable      in   1   symbol-valid level; only its rising edge is used
//   signal      in   2   01 dot, 10 dash, 00 space, 11 illegal (ignored)
//   char_valid  out  1   one-cycle pulse, char_code/char_err valid
//   char_code   out  6   0..25 A..Z, 26..35 digits 0..9, UNKNOWN_CODE, ERROR_CODE
//   char_err    out  1   set with char_valid when the character overflowed
//   busy        out  1   at least one symbol held
//   sym_count   out  3   number of symbols held
//   history     out  24  last four codes, [5:0] newest
//
// Configuration:
//   MORSE_HISTORY_EN  when defined, history keeps the last four emitted codes;
//                     otherwise history is tied to zero and has no registers.
//
// MAX_SYMBOLS legal range is 1..5.
// -----------------------------------------------------------------------------
module morse_symbol_assembler #(
   parameter int unsigned MAX_SYMBOLS  = 5,
   parameter logic [5:0]  UNKNOWN_CODE = 6'd36,
   parameter logic [5:0]  ERROR_CODE   = 6'd63
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [1:0]  signal,
   output logic        char_valid,
   output logic [5:0]  char_code,
   output logic        char_err,
   output logic        busy,
   output logic [2:0]  sym_count,
   output logic [23:0] history
);

   localparam logic [2:0] MaxCount = 3'(MAX_SYMBOLS);
   localparam logic [1:0] SigSpace = 2'b00;
   localparam logic [1:0] SigDot   = 2'b01;
   localparam logic [1:0] SigDash  = 2'b10;

   typedef enum logic [1:0] {
      StIdle,
      StCollect,
      StOverflow,
      StEmit
   } state_e;

   state_e      state_q, state_d;
   logic        en_q;
   logic [4:0]  pat_q, pat_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [5:0]  code_q, code_d;
   logic        err_q, err_d;
   logic        pend_valid_q, pend_valid_d;
   logic [1:0]  pend_sig_q, pend_sig_d;

   logic        strobe;
   logic        ev_valid;
   logic [1:0]  ev_sig;
   logic        ev_sym;
   logic        ev_space;
   logic        sym_bit;

   // Key is {length, pattern}; symbol k sits in bit k, dash = 1.
   function automatic logic [5:0] lookup(input logic [2:0] cnt, input logic [4:0] pat);
      logic [5:0] code;
      code = UNKNOWN_CODE;
      case ({cnt, pat})
         {3'd2, 5'b00010}: code = 6'd0;   // A .-
         {3'd4, 5'b00001}: code = 6'd1;   // B -...
         {3'd4, 5'b00101}: code = 6'd2;   // C -.-.
         {3'd3, 5'b00001}: code = 6'd3;   // D -..
         {3'd1, 5'b00000}: code = 6'd4;   // E .
         {3'd4, 5'b00100}: code = 6'd5;   // F ..-.
         {3'd3, 5'b00011}: code = 6'd6;   // G --.
         {3'd4, 5'b00000}: code = 6'd7;   // H ....
         {3'd2, 5'b00000}: code = 6'd8;   // I ..
         {3'd4, 5'b01110}: code = 6'd9;   // J .---
         {3'd3, 5'b00101}: code = 6'd10;  // K -.-
         {3'd4, 5'b00010}: code = 6'd11;  // L .-..
         {3'd2, 5'b00011}: code = 6'd12;  // M --
         {3'd2, 5'b00001}: code = 6'd13;  // N -.
         {3'd3, 5'b00111}: code = 6'd14;  // O ---
         {3'd4, 5'b00110}: code = 6'd15;  // P .--.
         {3'd4, 5'b01011}: code = 6'd16;  // Q --.-
         {3'd3, 5'b00010}: code = 6'd17;  // R .-.
         {3'd3, 5'b00000}: code = 6'd18;  // S ...
         {3'd1, 5'b00001}: code = 6'd19;  // T -
         {3'd3, 5'b00100}: code = 6'd20;  // U ..-
         {3'd4, 5'b01000}: code = 6'd21;  // V ...-
         {3'd3, 5'b00110}: code = 6'd22;  // W .--
         {3'd4, 5'b01001}: code = 6'd23;  // X -..-
         {3'd4, 5'b01101}: code = 6'd24;  // Y -.--
         {3'd4, 5'b00011}: code = 6'd25;  // Z --..
         {3'd5, 5'b11111}: code = 6'd26;  // 0 -----
         {3'd5, 5'b11110}: code = 6'd27;  // 1 .----
         {3'd5, 5'b11100}: code = 6'd28;  // 2 ..---
         {3'd5, 5'b11000}: code = 6'd29;  // 3 ...--
         {3'd5, 5'b10000}: code = 6'd30;  // 4 ....-
         {3'd5, 5'b00000}: code = 6'd31;  // 5 .....
         {3'd5, 5'b00001}: code = 6'd32;  // 6 -....
         {3'd5, 5'b00011}: code = 6'd33;  // 7 --...
         {3'd5, 5'b00111}: code = 6'd34;  // 8 ---..
         {3'd5, 5'b01111}: code = 6'd35;  // 9 ----.
         default:          code = UNKNOWN_CODE;
      endcase
      return code;
   endfunction

   assign strobe = enable & ~en_q;

   // In IDLE a strobe parked during EMIT takes priority; a fresh strobe cannot
   // coincide with it since enable must fall and rise again in between.
   always_comb begin
      ev_valid = strobe;
      ev_sig   = signal;
      if (state_q == StIdle && pend_valid_q) begin
         ev_valid = 1'b1;
         ev_sig   = pend_sig_q;
      end
   end

   assign ev_sym   = ev_valid & ((ev_sig == SigDot) | (ev_sig == SigDash));
   assign ev_space = ev_valid & (ev_sig == SigSpace);
   assign sym_bit  = (ev_sig == SigDash);

   always_comb begin
      state_d      = state_q;
      pat_d        = pat_q;
      cnt_d        = cnt_q;
      code_d       = code_q;
      err_d        = err_q;
      pend_valid_d = pend_valid_q;
      pend_sig_d   = pend_sig_q;

      case (state_q)
         StIdle: begin
            pend_valid_d = 1'b0;
            if (ev_sym) begin
               pat_d   = {4'b0000, sym_bit};
               cnt_d   = 3'd1;
               state_d = StCollect;
            end
         end
         StCollect: begin
            if (ev_sym) begin
               if (cnt_q < MaxCount) begin
                  pat_d = pat_q | (5'(sym_bit) << cnt_q);
                  cnt_d = cnt_q + 3'd1;
               end else begin
                  state_d = StOverflow;
               end
            end else if (ev_space) begin
               code_d  = lookup(cnt_q, pat_q);
               err_d   = 1'b0;
               state_d = StEmit;
            end
         end
         StOverflow: begin
            if (ev_space) begin
               code_d  = ERROR_CODE;
               err_d   = 1'b1;
               state_d = StEmit;
            end
         end
         StEmit: begin
            pat_d   = 5'd0;
            cnt_d   = 3'd0;
            state_d = StIdle;
            if (ev_sym || ev_space) begin
               pend_valid_d = 1'b1;
               pend_sig_d   = ev_sig;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         en_q         <= 1'b0;
         pat_q        <= 5'd0;
         cnt_q        <= 3'd0;
         code_q       <= 6'd0;
         err_q        <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_sig_q   <= 2'b00;
      end else begin
         state_q      <= state_d;
         en_q         <= enable;
         pat_q        <= pat_d;
         cnt_q        <= cnt_d;
         code_q       <= code_d;
         err_q        <= err_d;
         pend_valid_q <= pend_valid_d;
         pend_sig_q   <= pend_sig_d;
      end
   end

   assign char_valid = (state_q == StEmit);
   assign char_code  = code_q;
   assign char_err   = err_q;
   assign busy       = (cnt_q != 3'd0);
   assign sym_count  = cnt_q;

`ifdef MORSE_HISTORY_EN
   logic [23:0] history_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         history_q <= 24'd0;
      end else if (state_q == StEmit) begin
         history_q <= {history_q[17:0], code_q};
      end
   end

   assign history = history_q;
`else
   assign history = 24'd0;
`endif

endmodule

// File: tb/tb_morse_symbol_assembler.sv
module tb_morse_symbol_assembler;

   logic        clk;
   logic        reset_n;
   logic        enable;
   logic [1:0]  signal;
   logic        char_valid;
   logic [5:0]  char_code;
   logic        char_err;
   logic        busy;
   logic [2:0]  sym_count;
   logic [23:0] history;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          pulses   = 0;
   logic [5:0]  last_code = 6'd0;
   logic        last_err  = 1'b0;

   morse_symbol_assembler dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .signal     (signal),
      .char_valid (char_valid),
      .char_code  (char_code),
      .char_err   (char_err),
      .busy       (busy),
      .sym_count  (sym_count),
      .history    (history)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every output character, sampled away from the active edge.
   always @(negedge clk) begin
      if (char_valid === 1'b1) begin
         pulses    = pulses + 1;
         last_code = char_code;
         last_err  = char_err;
      end
   end

   typedef struct {
      string      syms;
      logic [5:0] code;
      logic       err;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [1:0] sig_of(input byte c);
      if (c == "." ) return 2'b01;
      if (c == "-" ) return 2'b10;
      if (c == " " ) return 2'b00;
      return 2'b11;
   endfunction

   // Called at posedge+1 with enable low; returns at posedge+1 with enable low.
   task automatic pulse(input logic [1:0] sig);
      enable = 1'b1;
      signal = sig;
      @(posedge clk);
      #1;
      enable = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      enable  = 1'b0;
      signal  = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int p0;

      vecs[0]  = '{".-",     6'd0,  1'b0};  // A
      vecs[1]  = '{"-----",  6'd26, 1'b0};  // 0
      vecs[2]  = '{"....",   6'd7,  1'b0};  // H
      vecs[3]  = '{"......", 6'd63, 1'b1};  // overflow
      vecs[4]  = '{"..--",   6'd36, 1'b0};  // not in table
      vecs[5]  = '{".x",     6'd4,  1'b0};  // illegal ignored -> E
      vecs[6]  = '{"-.--",   6'd24, 1'b0};  // Y
      vecs[7]  = '{"--..",   6'd25, 1'b0};  // Z
      vecs[8]  = '{"----.",  6'd35, 1'b0};  // 9
      vecs[9]  = '{".----",  6'd27, 1'b0};  // 1
      vecs[10] = '{"-",      6'd19, 1'b0};  // T
      vecs[11] = '{"-..-",   6'd23, 1'b0};  // X

      do_reset();
      check("reset_char_valid", 32'(char_valid), 32'd0);
      check("reset_char_code",  32'(char_code),  32'd0);
      check("reset_char_err",   32'(char_err),   32'd0);
      check("reset_busy",       32'(busy),       32'd0);
      check("reset_sym_count",  32'(sym_count),  32'd0);
      check("reset_history",    32'(history),    32'd0);

      // Latency: space strobe in cycle N, char_valid in cycle N+1.
      pulse(2'b01);
      pulse(2'b10);
      check("lat_busy", 32'(busy), 32'd1);
      enable = 1'b1;
      signal = 2'b00;
      check("lat_strobe_cycle_valid", 32'(char_valid), 32'd0);
      @(posedge clk);
      #1;
      enable = 1'b0;
      check("lat_next_cycle_valid", 32'(char_valid), 32'd1);
      check("lat_code_A", 32'(char_code), 32'd0);
      check("lat_err", 32'(char_err), 32'd0);
      @(posedge clk);
      #1;
      check("lat_pulse_one_cycle", 32'(char_valid), 32'd0);
      check("lat_idle_busy", 32'(busy), 32'd0);

      // Table-driven characters.
      for (int i = 0; i < 12; i++) begin
         p0 = pulses;
         for (int k = 0; k < vecs[i].syms.len(); k++) pulse(sig_of(vecs[i].syms[k]));
         pulse(2'b00);
         check($sformatf("vec%0d_pulses", i), 32'(pulses - p0), 32'd1);
         check($sformatf("vec%0d_code", i), 32'(last_code), 32'(vecs[i].code));
         check($sformatf("vec%0d_err", i), 32'(last_err), 32'(vecs[i].err));
         check($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
      end

      // Space in IDLE produces nothing.
      p0 = pulses;
      pulse(2'b00);
      pulse(2'b00);
      check("idle_space_no_valid", 32'(pulses - p0), 32'd0);

      // Illegal strobe leaves the count alone.
      pulse(2'b01);
      pulse(2'b01);
      check("illegal_before", 32'(sym_count), 32'd2);
      pulse(2'b11);
      check("illegal_after", 32'(sym_count), 32'd2);
      pulse(2'b00);
      check("illegal_code_I", 32'(last_code), 32'd8);

      // Overflow saturation.
      for (int k = 0; k < 5; k++) pulse(2'b01);
      check("ovf_count_full", 32'(sym_count), 32'd5);
      pulse(2'b01);
      check("ovf_count_sat6", 32'(sym_count), 32'd5);
      pulse(2'b10);
      check("ovf_count_sat7", 32'(sym_count), 32'd5);
      check("ovf_busy", 32'(busy), 32'd1);
      p0 = pulses;
      pulse(2'b00);
      check("ovf_pulses", 32'(pulses - p0), 32'd1);
      check("ovf_code", 32'(last_code), 32'd63);
      check("ovf_err", 32'(last_err), 32'd1);

      // Long enable is one symbol.
      enable = 1'b1;
      signal = 2'b01;
      repeat (10) @(posedge clk);
      #1;
      check("long_enable_count", 32'(sym_count), 32'd1);
      enable = 1'b0;
      @(posedge clk);
      #1;
      pulse(2'b00);
      check("long_enable_code_E", 32'(last_code), 32'd4);
      check("long_enable_err", 32'(last_err), 32'd0);

      // Reset mid-character discards the pattern.
      pulse(2'b01);
      pulse(2'b01);
      check("midreset_busy_before", 32'(busy), 32'd1);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      check("midreset_count", 32'(sym_count), 32'd0);
      p0 = pulses;
      pulse(2'b00);
      check("midreset_no_valid", 32'(pulses - p0), 32'd0);
      check("midreset_busy_after", 32'(busy), 32'd0);

      // History of A, E, H from a clean reset.
      do_reset();
      pulse(2'b01); pulse(2'b10); pulse(2'b00);
      pulse(2'b01); pulse(2'b00);
      for (int k = 0; k < 4; k++) pulse(2'b01);
      pulse(2'b00);
      check("hist_last_code_H", 32'(last_code), 32'd7);
`ifdef MORSE_HISTORY_EN
      check("history_AEH", 32'(history), 32'({6'd0, 6'd0, 6'd4, 6'd7}));
`else
      check("history_tied_zero", 32'(history), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
